// File: rtl/gsim_matvec_if.sv
// gsim_matvec_if: x input stream, b output stream and status of the banded multiplier.
// master drives x (producer side), slave is the multiplier.
interface gsim_matvec_if #(
    parameter int XW = 32,
    parameter int BW = 16
);
    logic          in_en;
    logic [XW-1:0] x_in;
    logic          in_ready;
    logic          out_valid;
    logic [BW-1:0] b_out;
    logic          busy;

    modport master (
        output in_en, x_in,
        input  in_ready, out_valid, b_out, busy
    );

    modport slave (
        input  in_en, x_in,
        output in_ready, out_valid, b_out, busy
    );
endinterface

// File: rtl/gsim_matvec.sv
// gsim_matvec: b = A*x for the 16x16 band matrix (20,-13,6,-1), Q16.16 in, int16 out.
// Define GSIM_MATVEC_ROUND_EN to round half toward +inf instead of flooring.
module gsim_matvec #(
    parameter int N    = 16,
    parameter int XW   = 32,
    parameter int FRAC = 16,
    parameter int BW   = 16,
    parameter int ACCW = 40
) (
    input  logic         clk,
    input  logic         reset_n,
    gsim_matvec_if.slave bus
);
    localparam int IW = $clog2(N);
    localparam logic signed [ACCW-1:0] BMAX =
        (ACCW'(1) <<< (BW - 1)) - ACCW'(1);
    localparam logic signed [ACCW-1:0] BMIN = -BMAX - ACCW'(1);
`ifdef GSIM_MATVEC_ROUND_EN
    localparam logic signed [ACCW-1:0] RND = ACCW'(1) <<< (FRAC - 1);
`else
    localparam logic signed [ACCW-1:0] RND = '0;
`endif

    typedef enum logic [1:0] {IDLE, LOAD, CALC} state_t;

    state_t                 state, state_nx;
    logic [IW-1:0]          idx, idx_nx;
    logic [IW-1:0]          row, row_nx;
    logic                   wr;
    logic signed [XW-1:0]   xbuf [N];
    logic signed [ACCW-1:0] acc_nx, acc, shd;
    logic                   acc_vld, vld;
    logic [BW-1:0]          b, b_nx;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            idx   <= '0;
            row   <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            row   <= row_nx;
        end
    end

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        row_nx   = row;
        wr       = 1'b0;
        unique case (state)
            IDLE: if (bus.in_en) begin
                wr       = 1'b1;
                idx_nx   = IW'(1);
                state_nx = LOAD;
            end
            LOAD: if (bus.in_en) begin
                wr     = 1'b1;
                idx_nx = idx + IW'(1);
                if (idx == IW'(N - 1)) begin
                    state_nx = CALC;
                    row_nx   = '0;
                    idx_nx   = '0;
                end
            end
            CALC: begin
                row_nx = row + IW'(1);
                if (row == IW'(N - 1))
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // idx is 0 in IDLE, so the first element also lands via xbuf[idx]
    always_ff @(posedge clk) begin
        if (wr)
            xbuf[idx] <= bus.x_in;
    end

    function automatic logic signed [ACCW-1:0] term(
        input int                   k,
        input logic signed [XW-1:0] x
    );
        logic signed [ACCW-1:0] v;
        v = ACCW'(x);
        case (k)
            0:       return (v <<< 4) + (v <<< 2);
            -1, 1:   return -((v <<< 3) + (v <<< 2) + v);
            -2, 2:   return (v <<< 2) + (v <<< 1);
            default: return -v;
        endcase
    endfunction

    always_comb begin
        int j;
        j      = 0;
        acc_nx = '0;
        for (int k = -3; k <= 3; k++) begin
            j = int'(row) + k;
            if (j >= 0 && j < N)
                acc_nx = acc_nx + term(k, xbuf[IW'(j)]);
        end
    end

    always_comb begin
        shd = (acc + RND) >>> FRAC;
        if (shd > BMAX)
            b_nx = BMAX[BW-1:0];
        else if (shd < BMIN)
            b_nx = BMIN[BW-1:0];
        else
            b_nx = shd[BW-1:0];
    end

    // two stages: row sum, then shift/saturate
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_vld <= 1'b0;
            acc     <= '0;
            vld     <= 1'b0;
            b       <= '0;
        end else begin
            acc_vld <= (state == CALC);
            acc     <= acc_nx;
            vld     <= acc_vld;
            if (acc_vld)
                b <= b_nx;
        end
    end

    assign bus.in_ready  = (state != CALC);
    assign bus.busy      = (state == CALC);
    assign bus.out_valid = vld;
    assign bus.b_out     = b;
endmodule

// File: tb/tb_gsim_matvec.sv
// tb_gsim_matvec: directed and random frames against a plain-arithmetic band model.
// Covers latency, stream length, saturation, rounding, ignored input and mid-frame reset.
module tb_gsim_matvec;
    typedef logic signed [31:0] vec_t [16];
    typedef int res_t [16];

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    gsim_matvec_if #(.XW(32), .BW(16)) bus ();

    gsim_matvec dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus.slave)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input longint got,
                         input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic model(input vec_t xv, output res_t e);
        int c[7] = '{-1, 6, -13, 20, -13, 6, -1};
        longint acc;
        for (int i = 0; i < 16; i++) begin
            acc = 0;
            for (int j = 0; j < 16; j++)
                if (j - i <= 3 && i - j <= 3)
                    acc += longint'(c[j - i + 3]) * longint'(xv[j]);
`ifdef GSIM_MATVEC_ROUND_EN
            acc += 32768;
`endif
            acc = acc >>> 16;
            if (acc > 32767) acc = 32767;
            if (acc < -32768) acc = -32768;
            e[i] = int'(acc);
        end
    endtask

    task automatic run_frame(input string name, input vec_t xv,
                             input res_t e, input bit gaps,
                             input bit pulse, input int abort_at);
        int lat;
        for (int i = 0; i < 16; i++) begin
            if (gaps)
                while ($urandom_range(0, 2) == 0) begin
                    bus.in_en = 1'b0;
                    bus.x_in  = $urandom;
                    @(negedge clk);
                end
            bus.in_en = 1'b1;
            bus.x_in  = xv[i];
            @(negedge clk);
        end
        bus.in_en = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check($sformatf("%s latency", name), lat, 2);
        if (!bus.out_valid) return;
        for (int r = 0; r < 16; r++) begin
            check($sformatf("%s valid[%0d]", name, r), bus.out_valid, 1);
            check($sformatf("%s b[%0d]", name, r),
                  $signed(bus.b_out), e[r]);
            if (r == abort_at) begin
                reset_n = 1'b0;
                #1;
                check($sformatf("%s abort valid", name), bus.out_valid, 0);
                check($sformatf("%s abort busy", name), bus.busy, 0);
                check($sformatf("%s abort ready", name), bus.in_ready, 1);
                @(negedge clk);
                reset_n = 1'b1;
                @(negedge clk);
                return;
            end
            if (r == 15)
                check($sformatf("%s ready last", name), bus.in_ready, 1);
            if (pulse && r <= 10) begin
                check($sformatf("%s ready calc", name), bus.in_ready, 0);
                bus.in_en = 1'b1;
                bus.x_in  = $urandom;
            end else begin
                bus.in_en = 1'b0;
            end
            @(negedge clk);
        end
        bus.in_en = 1'b0;
        check($sformatf("%s end valid", name), bus.out_valid, 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        vec_t xv, imp, ones;
        res_t e;
        res_t t2 = '{20, -13, 6, -1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        res_t t3 = '{12, -1, 5, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 5, -1, 12};
        res_t t4 = '{32767, -32768, 32767, -32768, 0, 0, 0, 0,
                     0, 0, 0, 0, 0, 0, 0, 0};
`ifdef GSIM_MATVEC_ROUND_EN
        res_t t5 = '{10, -6, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
`else
        res_t t5 = '{10, -7, 3, -1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
`endif
        res_t zero = '{default: 0};

        bus.in_en = 1'b0;
        bus.x_in  = '0;
        #2;
        check("rst valid", bus.out_valid, 0);
        check("rst b", bus.b_out, 0);
        check("rst busy", bus.busy, 0);
        check("rst ready", bus.in_ready, 1);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            xv[i]   = 0;
            imp[i]  = 0;
            ones[i] = 32'sh0001_0000;
        end
        imp[0] = 32'sh0001_0000;

        run_frame("t1", xv, zero, 1'b0, 1'b0, -1);
        run_frame("t2", imp, t2, 1'b1, 1'b0, -1);
        run_frame("t3", ones, t3, 1'b0, 1'b0, -1);
        xv[0] = 32'sh7FFF_FFFF;
        run_frame("t4", xv, t4, 1'b0, 1'b0, -1);
        xv[0] = 32'sh0000_8000;
        run_frame("t5", xv, t5, 1'b0, 1'b0, -1);
        run_frame("t6 pulse", ones, t3, 1'b0, 1'b1, -1);
        run_frame("t6 abort", ones, t3, 1'b0, 1'b0, 4);
        run_frame("t6 after", imp, t2, 1'b0, 1'b0, -1);

        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < 16; i++)
                xv[i] = (f < 3) ? ($signed($urandom) >>> 11)
                                : $signed($urandom);
            model(xv, e);
            run_frame($sformatf("rnd%0d", f), xv, e, 1'b1, f[0], -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
